// File: rtl/serial_adder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_adder_if : request/result bundle for the bit-serial adder
// Revision: 1.0
// ---------------------------------------------------------------------------
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (output start, a, b, c_in, input  busy, done, sum, c_out);
  modport slave  (input  start, a, b, c_in, output busy, done, sum, c_out);
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_adder : one full-adder slice reused per cycle, WIDTH cycles per add
// Revision: 1.0
// ---------------------------------------------------------------------------
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_adder_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] r;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;

  logic             p;
  logic             g0;
  logic             s;
  logic             g1;
  logic             co;
  logic [WIDTH-1:0] r_next;
  logic             last;

  half_adder u_ha0 (.a(sa[0]), .b(sb[0]), .s(p), .c(g0));
  half_adder u_ha1 (.a(p),     .b(carry), .s(s), .c(g1));
  assign co = g0 | g1;

  // r keeps only the WIDTH-1 bits gathered so far; the current s completes it
  assign r_next = {s, r};
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      sa      <= '0;
      sb      <= '0;
      r       <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sa     <= bus.a;
            sb     <= bus.b;
            carry  <= bus.c_in;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= S_ADD;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_ADD: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          r     <= r_next[WIDTH-1:1];
          carry <= co;
          cnt   <= cnt + CNT_W'(1);
          if (last) begin
            sum_q   <= r_next;
            c_out_q <= co;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state   <= S_DONE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
endmodule
`default_nettype wire
